// File: rtl/vga_timing_ctrl.sv
// VGA 640x480@60 timing: free-running h/v counters decoded into sync, active-video and a
// one-clock-early pixel request; upstream's registered pixel passes straight to the DAC.
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 40,
  parameter int H_LEFT   = 8,
  parameter int H_VALID  = 640,
  parameter int H_RIGHT  = 8,
  parameter int H_FRONT  = 8,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 25,
  parameter int V_TOP    = 8,
  parameter int V_VALID  = 480,
  parameter int V_BOTTOM = 8,
  parameter int V_FRONT  = 2
) (
  input  logic        iVGA_CLK,
  input  logic        sys_reset_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
  localparam int HS      = H_SYNC + H_BACK + H_LEFT;
  localparam int VS      = V_SYNC + V_BACK + V_TOP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S   = 10'(HS);
  localparam logic [9:0] H_ACT_E   = 10'(HS + H_VALID - 1);
  localparam logic [9:0] H_REQ_S   = 10'(HS - 1);
  localparam logic [9:0] H_REQ_E   = 10'(HS + H_VALID - 2);
  localparam logic [9:0] V_ACT_S   = 10'(VS);
  localparam logic [9:0] V_ACT_E   = 10'(VS + V_VALID - 1);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_act;
  logic       h_req;
  logic       v_act;
  logic       pix_req;

  always_ff @(posedge iVGA_CLK or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Request window leads the display window by one clock to cover upstream's register stage.
  always_comb begin
    hsync     = (cnt_h < H_SYNC_W);
    vsync     = (cnt_v < V_SYNC_W);
    h_act     = (cnt_h >= H_ACT_S) && (cnt_h <= H_ACT_E);
    h_req     = (cnt_h >= H_REQ_S) && (cnt_h <= H_REQ_E);
    v_act     = (cnt_v >= V_ACT_S) && (cnt_v <= V_ACT_E);
    rgb_valid = h_act && v_act;
    pix_req   = h_req && v_act;
    pix_x     = pix_req ? (cnt_h - H_REQ_S) : 10'h3FF;
    pix_y     = pix_req ? (cnt_v - V_ACT_S) : 10'h3FF;
    rgb       = rgb_valid ? pix_data : 16'h0000;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench: full-size timing generator plus a shrunken-geometry copy so whole frames fit the run;
// both are checked each clock against an elapsed-time position model and a pixel scoreboard.
module tb_vga_timing_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic [15:0] d_pix_data, d_rgb, s_pix_data, s_rgb;
  logic [9:0]  d_pix_x, d_pix_y, s_pix_x, s_pix_y;
  logic        d_hsync, d_vsync, d_rgb_valid, s_hsync, s_vsync, s_rgb_valid;

  vga_timing_ctrl u_dut (
    .iVGA_CLK(clk), .sys_reset_n(rst_n), .pix_data(d_pix_data),
    .pix_x(d_pix_x), .pix_y(d_pix_y), .hsync(d_hsync), .vsync(d_vsync),
    .rgb(d_rgb), .rgb_valid(d_rgb_valid)
  );

  vga_timing_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_LEFT(1), .H_VALID(10), .H_RIGHT(1), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_TOP(1), .V_VALID(4), .V_BOTTOM(1), .V_FRONT(1)
  ) u_small (
    .iVGA_CLK(clk), .sys_reset_n(rst_n), .pix_data(s_pix_data),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .hsync(s_hsync), .vsync(s_vsync),
    .rgb(s_rgb), .rgb_valid(s_rgb_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int kcnt  = 0;
  logic [15:0] d_q[$];
  logic [15:0] s_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, kcnt);
    end
  endtask

  function automatic logic [15:0] enc(input logic [9:0] x, input logic [9:0] y);
    return {x[4:0], y[5:0], x[9:5]};
  endfunction

  // Screen position follows from clocks elapsed since reset; returns {hs,vs,valid,x,y}.
  function automatic logic [22:0] model(input int k, input int ht, input int hsw, input int hst,
                                        input int hv, input int vt, input int vsw, input int vst,
                                        input int vv);
    int h, v;
    logic va, hs, vs, rv;
    logic [9:0] x, y;
    h  = k % ht;
    v  = (k / ht) % vt;
    va = (v >= vst) && (v < vst + vv);
    hs = (h < hsw);
    vs = (v < vsw);
    rv = va && (h >= hst) && (h < hst + hv);
    if (va && (h + 1 >= hst) && (h + 1 < hst + hv)) begin
      x = 10'(h + 1 - hst);
      y = 10'(v - vst);
    end else begin
      x = 10'h3FF;
      y = 10'h3FF;
    end
    return {hs, vs, rv, x, y};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) kcnt <= 0;
    else        kcnt <= kcnt + 1;
  end

  // Upstream renderer: registers the requested pixel; drives junk when nothing is requested.
  initial begin
    logic [15:0] dn, sn;
    d_pix_data = 16'hFFFF;
    s_pix_data = 16'h0000;
    forever begin
      @(negedge clk);
      dn = (d_pix_x != 10'h3FF) ? enc(d_pix_x, d_pix_y) : 16'hFFFF;
      sn = (s_pix_x != 10'h3FF) ? enc(s_pix_x, s_pix_y) : 16'($urandom);
      @(posedge clk);
      d_pix_data = dn;
      s_pix_data = sn;
    end
  end

  always @(negedge clk) begin : stim_model
    logic [22:0] de, se;
    de = model(kcnt, 800, 96, 144, 640, 525, 2, 35, 480);
    se = model(kcnt, 21, 4, 8, 10, 9, 1, 3, 4);
    check("d_timing", {9'b0, d_hsync, d_vsync, d_rgb_valid, d_pix_x, d_pix_y}, {9'b0, de});
    check("s_timing", {9'b0, s_hsync, s_vsync, s_rgb_valid, s_pix_x, s_pix_y}, {9'b0, se});
    if (!d_rgb_valid) check("d_blank_rgb", d_rgb, 0);
    if (!s_rgb_valid) check("s_blank_rgb", s_rgb, 0);
    if (de[19:10] != 10'h3FF) d_q.push_back(enc(de[19:10], de[9:0]));
    if (se[19:10] != 10'h3FF) s_q.push_back(enc(se[19:10], se[9:0]));
  end

  always @(posedge clk) begin : monitor
    #1;
    if (d_rgb_valid) begin
      if (d_q.size() == 0) check("d_sb_underflow", 1, 0);
      else check("d_rgb", d_rgb, d_q.pop_front());
    end
    if (s_rgb_valid) begin
      if (s_q.size() == 0) check("s_sb_underflow", 1, 0);
      else check("s_rgb", s_rgb, s_q.pop_front());
    end
  end

  task automatic wait_k(input int t);
    for (int i = 0; i < 100000 && kcnt != t; i++) @(negedge clk);
    check("reach_k", kcnt, t);
  endtask

  task automatic check_reset_vals();
    check("rst_hsync", d_hsync, 1);
    check("rst_vsync", d_vsync, 1);
    check("rst_valid", d_rgb_valid, 0);
    check("rst_rgb", d_rgb, 0);
    check("rst_pix_x", d_pix_x, 10'h3FF);
    check("rst_pix_y", d_pix_y, 10'h3FF);
    check("rst_s_sync", {s_hsync, s_vsync}, 2'b11);
  endtask

  initial begin
    int hs_cnt, svs_cnt, sval_cnt, r;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    #1 rst_n = 1'b1;

    hs_cnt = 0; svs_cnt = 0; sval_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      hs_cnt += int'(d_hsync);
      if (kcnt <= 189) begin
        svs_cnt  += int'(s_vsync);
        sval_cnt += int'(s_rgb_valid);
      end
      if (kcnt == 142) check("s_last_row", {s_pix_x, s_pix_y}, {10'd9, 10'd3});
      if (kcnt == 188) check("s_pre_wrap", {s_hsync, s_vsync, s_pix_y}, {2'b00, 10'h3FF});
      if (kcnt == 189) check("s_wrap", {s_hsync, s_vsync, s_pix_y}, {2'b11, 10'h3FF});
      if (kcnt == 799) check("d_hsync_low_end", d_hsync, 0);
      if (kcnt == 800) check("d_hsync_period", d_hsync, 1);
    end
    check("d_hsync_width", hs_cnt, 96);
    check("s_vsync_width", svs_cnt, 21);
    check("s_valid_per_frame", sval_cnt, 40);

    wait_k(28143);
    check("first_req", {d_pix_x, d_pix_y, d_rgb_valid}, {10'd0, 10'd0, 1'b0});
    wait_k(28144);
    check("first_valid", d_rgb_valid, 1);
    wait_k(28145);
    check("second_pix", d_rgb, 16'h0800);
    wait_k(28782);
    check("last_req", d_pix_x, 10'd639);
    wait_k(28783);
    check("last_pix", {d_pix_x, d_rgb_valid}, {10'h3FF, 1'b1});
    wait_k(28784);
    check("after_last", {d_rgb_valid, d_rgb}, {1'b0, 16'h0000});

    r = $urandom_range(0, 799);
    wait_k(800 * 37 + r);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat ($urandom_range(1, 5)) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_k(28143);
    check("rerun_first_req", {d_pix_x, d_pix_y, d_rgb_valid}, {10'd0, 10'd0, 1'b0});
    wait_k(28144);
    check("rerun_first_valid", d_rgb_valid, 1);
    wait_k(28808);
    check("d_sb_drained", d_q.size(), 0);
    check("s_sb_drained", s_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
VGA 640x480@60 Hz timing generator and pixel output stage, clocked by the ~25.175 MHz pixel clock. It generates free-running horizontal/vertical counters, hsync/vsync and an active-video qualifier. It issues a one-cycle-early pixel coordinate request (pix_x/pix_y) to the upstream drawing logic, which returns registered RGB565 data on pix_data. It sits between the frame/sprite renderer and the VGA DAC pins.

Parameters:
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 40, horizontal back porch
H_LEFT, 8, left border
H_VALID, 640, active pixels per line
H_RIGHT, 8, right border
H_FRONT, 8, horizontal front porch (H_TOTAL = sum = 800)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 25, vertical back porch
V_TOP, 8, top border
V_VALID, 480, active lines
V_BOTTOM, 8, bottom border
V_FRONT, 2, vertical front porch (V_TOTAL = sum = 525)

Ports:
iVGA_CLK  in  1  pixel clock; all state on rising edge
sys_reset_n  in  1  asynchronous, active-low reset
pix_data  in  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}, valid one clock after its pix_x/pix_y request
pix_x  out  10  requested column 0..639; 10'h3FF when no request
pix_y  out  10  requested row 0..479; 10'h3FF when no request
hsync  out  1  horizontal sync, active-high pulse
vsync  out  1  vertical sync, active-high pulse
rgb  out  16  RGB565 to DAC; 0 outside active video
rgb_valid  out  1  high during active 640x480 region

Behaviour:
- Sync pulses are active-high; the board-level sync polarity is fixed by this requirement.
- Two registered counters. cnt_h runs 0..H_TOTAL-1 (10 bits), increments every clock and wraps to 0.
- cnt_v runs 0..V_TOTAL-1. It increments only when cnt_h == H_TOTAL-1. It wraps to 0 when cnt_v == V_TOTAL-1 at that same point.
- Reset (async, sys_reset_n low): cnt_h = 0, cnt_v = 0, effective immediately.
- All outputs are combinational decodes of the counters plus pix_data; there are no other registers.
- hsync = (cnt_h < H_SYNC), i.e. high for cnt_h 0..95.
- vsync = (cnt_v < V_SYNC), i.e. high for cnt_v 0..1 (1600 clocks).
- H active start HS = H_SYNC+H_BACK+H_LEFT = 144. V active start VS = V_SYNC+V_BACK+V_TOP = 35.
- rgb_valid = (HS <= cnt_h <= HS+H_VALID-1 = 783) && (VS <= cnt_v <= VS+V_VALID-1 = 514).
- pix_req (internal) uses the same vertical window, with the horizontal window shifted one clock earlier: cnt_h in 143..782.
- pix_x = pix_req ? cnt_h-(HS-1) : 10'h3FF.
- pix_y = pix_req ? cnt_v-VS : 10'h3FF.
- rgb = rgb_valid ? pix_data : 16'h0000, combinational pass-through.
- Latency: coordinate (x,y) is presented at cycle t. Upstream registers its pixel, so pix_data at t+1 is for (x,y). That pixel appears on rgb at t+1, when rgb_valid is high.
- Reset values (counters at 0): hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=pix_y=10'h3FF.
- Frame period is 800*525 = 420000 clocks; line period is 800 clocks.
- pix_data X/garbage during blanking must not reach rgb.
- Reset mid-frame restarts timing at cnt_h=cnt_v=0 (start of a vsync+hsync pulse). There are no partial-state artifacts.

Test Plan:
- Reset: hold sys_reset_n low -> hsync=1, vsync=1, rgb_valid=0, rgb=0, pix_x=pix_y=3FF; release, count clocks -> hsync high exactly 96 clocks, period 800.
- Vertical timing: run 2 frames -> vsync high 1600 clocks, period 420000 clocks; 480 lines with rgb_valid per frame, each 640 clocks.
- First pixel: from reset release, cycle 28143 (35*800+143) -> pix_x=0,pix_y=0, rgb_valid=0. Cycle 28144 -> rgb_valid=1. Cycle 28782 -> pix_x=639. Cycle 28783 -> pix_x=3FF, rgb_valid still 1 (last pixel). Cycle 28784 -> rgb_valid=0.
- Data path: model upstream as a register of {pix_x[4:0],pix_y[5:0],pix_x[9:5]} -> rgb equals that encoding of the current displayed column/row on every valid cycle; drive pix_data=FFFF constantly -> rgb=0000 whenever rgb_valid=0.
- Wrap: at cnt_v=524,cnt_h=799 -> next clock hsync=1, vsync=1, pix_y=3FF; last active row pix_y=479.
- Mid-frame reset: assert reset at line 200, pixel 300 -> outputs return to reset values asynchronously; after release, first pixel again exactly 28143 clocks later.
